// File: rtl/subset_scanner.sv
// Raster-scans the full 2^(2*COORD_W) grid, classifying each point against up to
// eight circular sets and counting the points that satisfy the selected combination.
module subset_scanner #(
    parameter int COORD_W  = 4,
    parameter int NUM_SETS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_SETS*2*COORD_W-1:0] central,
    input  logic [NUM_SETS*2*COORD_W-1:0] radius_square,
    input  logic [1:0]                    mode,
    output logic                          busy,
    output logic                          hit_valid,
    output logic                          hit,
    output logic [2*COORD_W-1:0]          hit_pos,
    output logic                          valid,
    output logic [2*COORD_W:0]            count
);
    localparam int PW = 2 * COORD_W;
    localparam int DW = PW + 1;
    localparam int SW = NUM_SETS * PW;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                p_q, p_d;
    logic [SW-1:0]                cen_q, cen_d;
    logic [SW-1:0]                rad_q, rad_d;
    logic [1:0]                   mode_q, mode_d;

    logic                         s1_vld_q, s1_vld_d;
    logic [PW-1:0]                s1_pos_q, s1_pos_d;
    logic [NUM_SETS-1:0][PW-1:0]  dx2_q, dx2_d;
    logic [NUM_SETS-1:0][PW-1:0]  dy2_q, dy2_d;

    logic                         hv_q, hv_d;
    logic                         hit_q, hit_d;
    logic [PW-1:0]                hpos_q, hpos_d;
    logic [DW-1:0]                cnt_q, cnt_d;

    logic [NUM_SETS-1:0][COORD_W-1:0] dx_c, dy_c;
    logic [NUM_SETS-1:0][DW-1:0]      dist_c;
    logic [NUM_SETS-1:0]              in_c;
    logic [3:0]                       n_in;
    logic                             others_in;
    logic                             comb_hit;

    // Stage 1: per-set squared axis distances of the point currently being issued
    always_comb begin
        dx_c  = '0;
        dy_c  = '0;
        dx2_d = '0;
        dy2_d = '0;
        for (int unsigned i = 0; i < NUM_SETS; i++) begin
            logic [COORD_W-1:0] cx, cy, px, py;
            cx = cen_q[i*PW+COORD_W +: COORD_W];
            cy = cen_q[i*PW +: COORD_W];
            px = p_q[PW-1:COORD_W];
            py = p_q[COORD_W-1:0];
            dx_c[i]  = (px >= cx) ? (px - cx) : (cx - px);
            dy_c[i]  = (py >= cy) ? (py - cy) : (cy - py);
            dx2_d[i] = PW'(dx_c[i]) * PW'(dx_c[i]);
            dy2_d[i] = PW'(dy_c[i]) * PW'(dy_c[i]);
        end
        s1_vld_d = (state_q == SCAN);
        s1_pos_d = p_q;
    end

    // Stage 2: membership tests and set combination
    always_comb begin
        dist_c    = '0;
        in_c      = '0;
        n_in      = '0;
        others_in = 1'b0;
        for (int unsigned i = 0; i < NUM_SETS; i++) begin
            dist_c[i] = {1'b0, dx2_q[i]} + {1'b0, dy2_q[i]};
            in_c[i]   = (dist_c[i] <= {1'b0, rad_q[i*PW +: PW]});
            n_in      = n_in + 4'(in_c[i]);
            if (i != 0) others_in = others_in | in_c[i];
        end
        case (mode_q)
            2'd0:    comb_hit = (n_in != '0);
            2'd1:    comb_hit = (n_in == 4'(NUM_SETS));
            2'd2:    comb_hit = (n_in == 4'd1);
            default: comb_hit = in_c[0] & ~others_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cen_d   = cen_q;
        rad_d   = rad_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        hv_d    = s1_vld_q;
        hit_d   = s1_vld_q & comb_hit;
        hpos_d  = s1_pos_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SCAN;
                    p_d     = '0;
                    cen_d   = central;
                    rad_d   = radius_square;
                    mode_d  = mode;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                p_d = p_q + PW'(1);
                if (p_q == '1) state_d = DRAIN;
            end
            // Leave once the final grid point has reached the output register
            DRAIN: begin
                if (hv_q && (hpos_q == '1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (s1_vld_q && comb_hit) cnt_d = cnt_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            cen_q    <= '0;
            rad_q    <= '0;
            mode_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_pos_q <= '0;
            dx2_q    <= '0;
            dy2_q    <= '0;
            hv_q     <= 1'b0;
            hit_q    <= 1'b0;
            hpos_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cen_q    <= cen_d;
            rad_q    <= rad_d;
            mode_q   <= mode_d;
            s1_vld_q <= s1_vld_d;
            s1_pos_q <= s1_pos_d;
            dx2_q    <= dx2_d;
            dy2_q    <= dy2_d;
            hv_q     <= hv_d;
            hit_q    <= hit_d;
            hpos_q   <= hpos_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign valid     = (state_q == DONE);
    assign hit_valid = hv_q;
    assign hit       = hit_q;
    assign hit_pos   = hpos_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_subset_scanner.sv
// Randomized and directed bench for subset_scanner; a cycle-level behavioural model
// predicts every output from the scan start edge and the geometry of the sets.
module tb_subset_scanner;
    localparam int CW = 4;
    localparam int NS = 3;
    localparam int PW = 2 * CW;
    localparam int N  = 1 << PW;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [NS*PW-1:0]  central, radius_square;
    logic [1:0]        mode;
    logic              busy, hit_valid, hit, valid;
    logic [PW-1:0]     hit_pos;
    logic [PW:0]       count;

    always #5 clk = ~clk;

    subset_scanner #(.COORD_W(CW), .NUM_SETS(NS)) dut (
        .clk(clk), .rst(rst), .en(en), .central(central),
        .radius_square(radius_square), .mode(mode), .busy(busy),
        .hit_valid(hit_valid), .hit(hit), .hit_pos(hit_pos),
        .valid(valid), .count(count)
    );

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: scan timeline measured in edges since the accepting edge
    int m_cx[NS], m_cy[NS], m_r2[NS];
    int m_mode;
    bit m_active = 0;
    int m_k = 0;
    int m_count = 0;
    int m_E = 0;
    int cyc = 0;

    function automatic bit model_hit(input int p);
        int x, y, d, n, oth;
        bit in0;
        x = p / (1 << CW);
        y = p % (1 << CW);
        n = 0; oth = 0; in0 = 0;
        for (int i = 0; i < NS; i++) begin
            d = (x - m_cx[i]) * (x - m_cx[i]) + (y - m_cy[i]) * (y - m_cy[i]);
            if (d <= m_r2[i]) begin
                n++;
                if (i == 0) in0 = 1; else oth++;
            end
        end
        case (m_mode)
            0: return n > 0;
            1: return n == NS;
            2: return n == 1;
            default: return in0 && (oth == 0);
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 0; m_k = 0; m_count = 0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1; m_k = 0; m_count = 0; m_E = cyc;
                m_mode = mode;
                for (int i = 0; i < NS; i++) begin
                    m_cx[i] = central[i*PW+CW +: CW];
                    m_cy[i] = central[i*PW +: CW];
                    m_r2[i] = radius_square[i*PW +: PW];
                end
            end
        end else if (m_k == N + 2) begin
            m_active = 0;
        end else begin
            m_k++;
            if (m_k >= 2 && m_k <= N + 1) m_count += int'(model_hit(m_k - 2));
        end
    end

    // Observation trackers for directed checks
    int done_pulses = 0, done_count = 0, valid_cyc = 0;
    int first_hv_cyc, first_hv_pos, last_hv_cyc, last_hv_pos;
    int busy_cycles, dut_hits, last_hit_pos;
    bit seen_hv;

    always @(negedge clk) begin
        bit e_hv;
        e_hv = m_active && m_k >= 2 && m_k <= N + 1;
        check("busy", busy, m_active);
        check("valid", valid, m_active && m_k == N + 2);
        check("hit_valid", hit_valid, e_hv);
        check("count", count, m_count);
        if (e_hv) begin
            check("hit", hit, model_hit(m_k - 2));
            check("hit_pos", hit_pos, m_k - 2);
        end
        if (busy) busy_cycles++;
        if (hit_valid) begin
            if (!seen_hv) begin
                seen_hv = 1; first_hv_cyc = cyc; first_hv_pos = hit_pos;
            end
            last_hv_cyc = cyc; last_hv_pos = hit_pos;
            if (hit) begin dut_hits++; last_hit_pos = hit_pos; end
        end
        if (valid) begin
            done_pulses++; done_count = count; valid_cyc = cyc;
        end
    end

    int pulse_base;

    task automatic set_cfg(input int cx0, input int cy0, input int r0,
                           input int cx1, input int cy1, input int r1,
                           input int cx2, input int cy2, input int r2, input int md);
        int cx[NS], cy[NS], rr[NS];
        cx = '{cx0, cx1, cx2}; cy = '{cy0, cy1, cy2}; rr = '{r0, r1, r2};
        for (int i = 0; i < NS; i++) begin
            central[i*PW+CW +: CW]   = CW'(cx[i]);
            central[i*PW +: CW]      = CW'(cy[i]);
            radius_square[i*PW +: PW] = PW'(rr[i]);
        end
        mode = 2'(md);
    endtask

    task automatic start_scan();
        for (int i = 0; i < 400 && m_active; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #2;
        seen_hv = 0; busy_cycles = 0; dut_hits = 0; last_hit_pos = -1;
        pulse_base = done_pulses;
        en = 1;
        @(posedge clk); #2;
        en = 0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400 && done_pulses == pulse_base; i++) @(posedge clk);
        #2;
        if (done_pulses == pulse_base) begin
            compared++; mismatched++;
            $display("FAIL %s: no valid pulse within 400 cycles", nm);
        end
    endtask

    initial begin
        int exp_a[4];
        exp_a = '{14, 0, 13, 13};
        rst = 1; en = 0; central = '0; radius_square = '0; mode = '0;
        repeat (2) @(posedge clk);
        #2 en = 1;
        @(posedge clk); #2;
        rst = 0; en = 0;
        repeat (3) @(negedge clk);
        check("rst_en_busy", busy, 0);
        check("rst_hit_pos", hit_pos, 0);
        check("rst_count", count, 0);

        // Scenario A under all four modes; first pass also pins the timeline
        for (int md = 0; md < 4; md++) begin
            set_cfg(4, 4, 4, 15, 15, 0, 15, 15, 0, md);
            start_scan();
            wait_done("scenA_done");
            check("scenA_count", done_count, exp_a[md]);
            check("scenA_model", m_count, exp_a[md]);
            if (md == 0) begin
                check("first_hv_lat", first_hv_cyc - m_E, 2);
                check("first_hv_pos", first_hv_pos, 0);
                check("last_hv_lat", last_hv_cyc - m_E, N + 1);
                check("last_hv_pos", last_hv_pos, N - 1);
                check("valid_lat", valid_cyc - m_E, N + 2);
                check("busy_len", busy_cycles, N + 3);
            end
        end

        set_cfg(8, 8, 0, 8, 8, 0, 8, 8, 0, 1);
        start_scan();
        wait_done("centre_done");
        check("centre_count", done_count, 1);
        check("centre_hits", dut_hits, 1);
        check("centre_pos", last_hit_pos, 'h88);

        set_cfg(7, 7, 255, 7, 7, 255, 7, 7, 255, 0);
        start_scan();
        wait_done("full_done");
        check("full_count", done_count, 256);
        check("full_hits", dut_hits, 256);
        check("full_model", m_count, 256);

        // Second en mid-scan with different inputs must be ignored
        set_cfg(4, 4, 4, 15, 15, 0, 15, 15, 0, 0);
        start_scan();
        repeat (50) @(posedge clk);
        #2 set_cfg(7, 7, 255, 7, 7, 255, 7, 7, 255, 1);
        en = 1;
        @(posedge clk); #2 en = 0;
        wait_done("mid_done");
        check("mid_count", done_count, 14);
        repeat (20) @(posedge clk);
        check("mid_pulses", done_pulses - pulse_base, 1);

        // Reset 100 cycles into a scan
        set_cfg(4, 4, 4, 15, 15, 0, 15, 15, 0, 0);
        start_scan();
        repeat (99) @(posedge clk);
        #2 rst = 1;
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hv", hit_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_hpos", hit_pos, 0);
        check("rst_valid", valid, 0);
        check("rst_cnt", count, 0);
        repeat (300) @(posedge clk);
        check("rst_no_valid", done_pulses - pulse_base, 0);
        start_scan();
        wait_done("post_rst_done");
        check("post_rst_count", done_count, 14);

        // Random scans with ignored mid-scan en pulses carrying new inputs
        for (int t = 0; t < 6; t++) begin
            set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 120),
                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 120),
                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 120),
                    $urandom_range(0, 3));
            start_scan();
            repeat ($urandom_range(5, 200)) @(posedge clk);
            #2 set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                       $urandom_range(0, 3));
            en = 1;
            @(posedge clk); #2 en = 0;
            wait_done("rand_done");
            check("rand_count", done_count, m_count);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/subset_scanner.md
SUBSET_SCANNER -- requirements
Module: subset_scanner

Interface
REQ-001 The block SHALL have parameter COORD_W, default 4, meaning the bit width of one grid coordinate (x or y).
REQ-002 The block SHALL have parameter NUM_SETS, default 3, meaning the number of circular sets; the legal range is 1..8.
REQ-003 The block SHALL have one clock, clk, with a synchronous active-high reset, rst; all state SHALL update on the rising edge of clk.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  start pulse, sampled only in IDLE
- central  in  NUM_SETS*2*COORD_W  centre of set i at bits [(i+1)*2*COORD_W-1 : i*2*COORD_W], packed {x,y} with x in the upper half
- radius_square  in  NUM_SETS*2*COORD_W  r² of set i, packed with the same indexing as central
- mode  in  2  set combination: 0 = union, 1 = intersection, 2 = exactly one, 3 = set0 minus the union of the others
- busy  out  1  scan in progress
- hit_valid  out  1  hit/hit_pos qualifier, one per grid point
- hit  out  1  point satisfies the mode
- hit_pos  out  2*COORD_W  grid point {x,y}
- valid  out  1  one-cycle pulse, count final
- count  out  2*COORD_W+1  number of points that hit

Function
REQ-005 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-006 In IDLE with en=1, the block SHALL latch central, radius_square and mode, clear count, and enter SCAN.
- Later input changes SHALL NOT affect the running scan.
REQ-007 In SCAN, the block SHALL issue one grid point per cycle, from p=0 up to p=N-1, where N=2^(2*COORD_W).
- Point p SHALL be {x,y}=p, so x is the slow index and y the fast index.
- After issuing p=N-1 the block SHALL enter DRAIN.
REQ-008 The pipeline SHALL have 2 stages.
- Stage 1: |x-cx|² and |y-cy|² for each set, each 2*COORD_W bits wide.
- Stage 2: dist² = sum, 2*COORD_W+1 bits, with no overflow; in_i = (dist² <= zero-extended r²_i); combine per mode; register hit/hit_pos/hit_valid; add hit to count.
REQ-009 If en is sampled at edge E, point p SHALL appear with hit_valid=1 in cycle E+3+p.
REQ-010 DRAIN SHALL last until the last point is accumulated; the FSM SHALL then enter DONE, in cycle E+N+3.
REQ-011 In DONE, valid SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-012 busy SHALL be 1 from cycle E+1 through the DONE cycle inclusive, and 0 otherwise.
REQ-013 count SHALL hold its final value from the DONE cycle until the next accepted en.
REQ-014 en asserted while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-015 Mode combination rules:
- Mode 2 SHALL be true when exactly one in_i is set, not when an odd number of in_i are set.
- Mode 3 with NUM_SETS=1 SHALL equal set0.
REQ-016 r²=0 SHALL include the centre point only.
- r² >= the maximum dist² SHALL include the whole grid.
REQ-017 count SHALL reach N without wrapping; N=256 fits in 9 bits at the default parameters.

Reset
REQ-018 rst=1 SHALL force the FSM to IDLE and set busy=0, hit_valid=0, hit=0, hit_pos=0, valid=0 and count=0 on the next edge.
- This SHALL hold in every state, including mid-SCAN and mid-DRAIN.
- Pipeline contents SHALL be discarded, and no valid pulse SHALL follow.
REQ-019 en sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-020 The bench SHALL cover the following directed scenarios at default parameters (COORD_W=4, NUM_SETS=3):
- A=(4,4) r²=4, B=C=(15,15) r²=0: mode 0 -> count=14; mode 1 -> count=0; mode 2 -> count=13; mode 3 -> count=13.
- All sets at (8,8) with r²=0, mode 1 -> count=1 and a single hit with hit_pos=0x88.
- All sets at (7,7) with r²=255, mode 0 -> count=256 and a hit on every point.
- en at edge E -> first hit_valid at E+3 with hit_pos=0x00, last at E+258 with hit_pos=0xFF, valid at E+259, busy high from E+1 to E+259.
- Second en pulse mid-scan with changed inputs -> result equal to the first scan's inputs, and exactly one valid pulse.
- rst 100 cycles after en -> all outputs 0 and no valid pulse; a following en completes a correct scan.
